// File: rtl/bus_codes_pkg.sv
// Shared bus codes, op encodings and transfer-controller state set.
package bus_codes_pkg;

  // Bus source codes (bit index into src_sel)
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_PC     = 5'd16;
  localparam logic [4:0] SRC_MDR    = 5'd17;
  localparam logic [4:0] SRC_INPORT = 5'd18;
  localparam logic [4:0] SRC_HI     = 5'd19;
  localparam logic [4:0] SRC_LO     = 5'd20;
  localparam logic [4:0] SRC_ZHI    = 5'd21;
  localparam logic [4:0] SRC_ZLO    = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;

  // Bus destination codes (bit index into dst_load)
  localparam logic [4:0] DST_R0      = 5'd0;
  localparam logic [4:0] DST_R15     = 5'd15;
  localparam logic [4:0] DST_PC      = 5'd16;
  localparam logic [4:0] DST_MDR     = 5'd17;
  localparam logic [4:0] DST_HI      = 5'd18;
  localparam logic [4:0] DST_LO      = 5'd19;
  localparam logic [4:0] DST_MAR     = 5'd20;
  localparam logic [4:0] DST_OUTPORT = 5'd21;

  typedef enum logic [1:0] {
    OP_MOVE    = 2'b00,
    OP_ALU     = 2'b01,
    OP_WIDE    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ERR    = 4'd1,
    T_MV   = 4'd2,
    T_A    = 4'd3,
    T_B    = 4'd4,
    T_WAIT = 4'd5,
    T_W    = 4'd6,
    T_H    = 4'd7,
    T_L    = 4'd8
  } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Code-to-one-hot decoder with enable; codes outside 0..N-1 decode to zero.
module onehot_dec #(
  parameter int unsigned N = 24,
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] code_i,
  input  logic         en_i,
  output logic [N-1:0] onehot_o
);

  // Compare against every index so out-of-range codes never set a bit
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en_i && (code_i == W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Datapath bus transfer controller: steps MOVE / ALU / WIDE requests
// through register-transfer T-states and drives one-hot bus selects.
module bus_xfer_ctrl
  import bus_codes_pkg::*;
#(
  parameter int unsigned NSRC    = 24,
  parameter int unsigned NDST    = 22,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [4:0]      src_a,
  input  logic [4:0]      src_b,
  input  logic [4:0]      dst,
  input  logic [4:0]      alu_fn_in,
  output logic [NSRC-1:0] src_sel,
  output logic [NDST-1:0] dst_load,
  output logic            y_load,
  output logic            z_load,
  output logic [4:0]      alu_fn,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [4:0] src_a_q, src_a_d;
  logic [4:0] src_b_q, src_b_d;
  logic [4:0] dst_q, dst_d;
  logic [4:0] fn_q, fn_d;
  logic [2:0] cnt_q, cnt_d;

  logic       req_legal;
  state_e     after_wait;
  logic [4:0] src_code, dst_code;
  logic       src_en, dst_en;

  // Request validation on the raw inputs; only steers the next state
  always_comb begin
    req_legal = 1'b1;
    if (op == OP_ILLEGAL)                            req_legal = 1'b0;
    if (32'(src_a) >= NSRC)                          req_legal = 1'b0;
    if ((op != OP_MOVE) && (32'(src_b) >= NSRC))     req_legal = 1'b0;
    if ((op != OP_WIDE) && (32'(dst) >= NDST))       req_legal = 1'b0;
  end

  // Next state, operand capture and ALU latency counter
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    fn_d       = fn_q;
    cnt_d      = cnt_q;
    after_wait = (op_q == OP_WIDE) ? T_H : T_W;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          src_a_d = src_a;
          src_b_d = src_b;
          dst_d   = dst;
          fn_d    = alu_fn_in;
          if (!req_legal)            state_d = ERR;
          else if (op == OP_MOVE)    state_d = T_MV;
          else                       state_d = T_A;
        end
      end
      T_A: state_d = T_B;
      T_B: begin
        // Z needs ALU_LAT-1 extra cycles; the wait state is bypassed at 1
        cnt_d = 3'(ALU_LAT - 1);
        if (ALU_LAT == 1) state_d = after_wait;
        else              state_d = T_WAIT;
      end
      T_WAIT: begin
        if (cnt_q <= 3'd1) state_d = after_wait;
        else               cnt_d   = cnt_q - 3'd1;
      end
      T_H:     state_d = T_L;
      ERR,
      T_MV,
      T_W,
      T_L:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-operand registers; clr aborts any transfer
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= OP_MOVE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode purely from registered state and captured operands
  always_comb begin
    src_code = '0;
    src_en   = 1'b0;
    dst_code = '0;
    dst_en   = 1'b0;
    y_load   = 1'b0;
    z_load   = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      T_MV: begin
        src_code = src_a_q; src_en = 1'b1;
        dst_code = dst_q;   dst_en = 1'b1;
        done     = 1'b1;
      end
      T_A: begin
        src_code = src_a_q; src_en = 1'b1;
        y_load   = 1'b1;
      end
      T_B: begin
        src_code = src_b_q; src_en = 1'b1;
        z_load   = 1'b1;
      end
      T_W: begin
        src_code = SRC_ZLO; src_en = 1'b1;
        dst_code = dst_q;   dst_en = 1'b1;
        done     = 1'b1;
      end
      T_H: begin
        src_code = SRC_ZHI; src_en = 1'b1;
        dst_code = DST_HI;  dst_en = 1'b1;
      end
      T_L: begin
        src_code = SRC_ZLO; src_en = 1'b1;
        dst_code = DST_LO;  dst_en = 1'b1;
        done     = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign alu_fn = fn_q;

  onehot_dec #(.N(NSRC), .W(5)) u_src_dec (
    .code_i   (src_code),
    .en_i     (src_en),
    .onehot_o (src_sel)
  );

  onehot_dec #(.N(NDST), .W(5)) u_dst_dec (
    .code_i   (dst_code),
    .en_i     (dst_en),
    .onehot_o (dst_load)
  );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: two instances (ALU_LAT=3 and 1) share
// stimulus; a transaction-level model queues the expected per-cycle outputs.
module tb_bus_xfer_ctrl;

  typedef struct packed {
    logic        busy;
    logic [23:0] src;
    logic [21:0] dst;
    logic        y;
    logic        z;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic [4:0] fn;
  } rec_t;

  logic       clk = 1'b0;
  logic       clr, start;
  logic [1:0] op;
  logic [4:0] src_a, src_b, dst, alu_fn_in;

  logic [23:0] src_sel  [2];
  logic [21:0] dst_load [2];
  logic [4:0]  alu_fn   [2];
  logic        y_load [2], z_load [2], busy [2], done [2], err [2];

  rec_t exp_q [2][$];
  int   left [2];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NSRC(24), .NDST(22), .ALU_LAT(3)) dut0 (
    .clk(clk), .clr(clr), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst(dst), .alu_fn_in(alu_fn_in), .src_sel(src_sel[0]), .dst_load(dst_load[0]),
    .y_load(y_load[0]), .z_load(z_load[0]), .alu_fn(alu_fn[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]));

  bus_xfer_ctrl #(.NSRC(24), .NDST(22), .ALU_LAT(1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst(dst), .alu_fn_in(alu_fn_in), .src_sel(src_sel[1]), .dst_load(dst_load[1]),
    .y_load(y_load[1]), .z_load(z_load[1]), .alu_fn(alu_fn[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]));

  function automatic int lat_of(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic chk(input bit ok, input string name, input int d,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, req, $time);
    end
  endtask

  function automatic obs_t cyc(int s, int dd, bit y, bit z, bit dn, bit e);
    obs_t r;
    r      = '0;
    r.busy = 1'b1;
    if (s >= 0)  r.src = 24'(1) << s;
    if (dd >= 0) r.dst = 22'(1) << dd;
    r.y    = y;
    r.z    = z;
    r.done = dn;
    r.err  = e;
    return r;
  endfunction

  // Expected cycle-by-cycle response of one accepted request
  task automatic push_req(input int d);
    rec_t r;
    int   a, b, t, lat;
    bit   legal;
    a     = int'(src_a);
    b     = int'(src_b);
    t     = int'(dst);
    lat   = lat_of(d);
    legal = (op != 2'b11) && (a < 24) && (op == 2'b00 || b < 24) &&
            (op == 2'b10 || t < 22);
    r.fn  = alu_fn_in;
    if (!legal) begin
      r.o = cyc(-1, -1, 0, 0, 0, 1); exp_q[d].push_back(r);
    end else if (op == 2'b00) begin
      r.o = cyc(a, t, 0, 0, 1, 0); exp_q[d].push_back(r);
    end else begin
      r.o = cyc(a, -1, 1, 0, 0, 0); exp_q[d].push_back(r);
      r.o = cyc(b, -1, 0, 1, 0, 0); exp_q[d].push_back(r);
      for (int i = 1; i < lat; i++) begin
        r.o = cyc(-1, -1, 0, 0, 0, 0); exp_q[d].push_back(r);
      end
      if (op == 2'b01) begin
        r.o = cyc(22, t, 0, 0, 1, 0); exp_q[d].push_back(r);
      end else begin
        r.o = cyc(21, 18, 0, 0, 0, 0); exp_q[d].push_back(r);
        r.o = cyc(22, 19, 0, 0, 1, 0); exp_q[d].push_back(r);
      end
    end
    left[d] = exp_q[d].size();
  endtask

  // One clock: drive inputs, let the model see the same edge, move off the edge
  task automatic step(input bit c, input bit s, input logic [1:0] o,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] t, input logic [4:0] f);
    clr = c; start = s; op = o; src_a = a; src_b = b; dst = t; alu_fn_in = f;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        exp_q[d].delete();
        left[d] = 0;
      end else if (left[d] > 0) begin
        left[d]--;
      end else if (start) begin
        push_req(d);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Monitor: every cycle compare DUT outputs against the queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        obs_t act;
        rec_t r;
        act = {busy[d], src_sel[d], dst_load[d], y_load[d], z_load[d], done[d], err[d]};
        chk(($countones(src_sel[d]) <= 1) && ($countones(dst_load[d]) <= 1),
            "onehot", d, {18'd0, src_sel[d], dst_load[d]}, 64'd0);
        if (exp_q[d].size() > 0) begin
          r = exp_q[d].pop_front();
          chk(act == r.o, "xfer_cycle", d, 64'(act), 64'(r.o));
          chk(alu_fn[d] == r.fn, "alu_fn", d, 64'(alu_fn[d]), 64'(r.fn));
        end else begin
          chk(act == '0, "idle_outputs", d, 64'(act), 64'd0);
        end
      end
    end
  end

  initial begin
    left[0] = 0;
    left[1] = 0;
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 2'b01, 5'd1, 5'd2, 5'd3, 5'd9);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs_t act;
      act = {busy[d], src_sel[d], dst_load[d], y_load[d], z_load[d], done[d], err[d]};
      chk(act == '0, "reset_outputs", d, 64'(act), 64'd0);
      chk(alu_fn[d] == 5'd0, "reset_alu_fn", d, 64'(alu_fn[d]), 64'd0);
    end
    mon_en = 1'b1;

    // MOVE PC -> R5
    step(0, 1, 2'b00, 5'd16, 5'd0, 5'd5, 5'd0);
    idle(2);
    // ALU R2,R3 -> R7 fn 04
    step(0, 1, 2'b01, 5'd2, 5'd3, 5'd7, 5'h04);
    idle(6);
    // WIDE R4,R9
    step(0, 1, 2'b10, 5'd4, 5'd9, 5'd31, 5'h11);
    idle(7);
    // Illegal: op=11, MOVE src 24, ALU dst 22, WIDE src_b 30
    step(0, 1, 2'b11, 5'd1, 5'd1, 5'd1, 5'd3);
    idle(1);
    step(0, 1, 2'b00, 5'd24, 5'd0, 5'd1, 5'd0);
    idle(1);
    step(0, 1, 2'b01, 5'd1, 5'd2, 5'd22, 5'd0);
    idle(1);
    step(0, 1, 2'b10, 5'd1, 5'd30, 5'd0, 5'd0);
    idle(1);
    // Boundary-legal codes, src_a == src_b, dst equal to a source
    step(0, 1, 2'b01, 5'd23, 5'd23, 5'd21, 5'h1f);
    idle(6);
    step(0, 1, 2'b00, 5'd23, 5'd0, 5'd21, 5'd0);
    idle(2);
    // clr during T_B, start in the clr cycle ignored, next start accepted
    step(0, 1, 2'b01, 5'd2, 5'd3, 5'd7, 5'h04);
    idle(1);
    step(1, 1, 2'b00, 5'd1, 5'd0, 5'd2, 5'd0);
    step(0, 1, 2'b00, 5'd3, 5'd0, 5'd4, 5'd0);
    idle(2);
    // start held high with back-to-back MOVEs
    for (int i = 0; i < 10; i++)
      step(0, 1, 2'b00, 5'(i), 5'd0, 5'(i + 1), 5'(i));
    idle(2);
    // starts during an ALU op are ignored
    step(0, 1, 2'b01, 5'd5, 5'd6, 5'd8, 5'h02);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 5'd9, 5'd0, 5'd10, 5'd0);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int         k;
      logic [1:0] o;
      logic [4:0] a, b, t;
      k = int'($urandom_range(0, 9));
      o = (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
      a = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      b = ($urandom_range(0, 19) == 0 && o != 2'b00) ? 5'($urandom_range(24, 31))
                                                     : 5'($urandom_range(0, 23));
      t = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), o, a, b, t,
           5'($urandom));
    end

    idle(15);
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++)
      chk(exp_q[d].size() == 0, "drained", d, 64'(exp_q[d].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
